gam_node_memory: RTL and testbench
==================================

Name: gam_node_memory

Overview:
- Clocked, parametrised node store for the GAM memory layer: NUM_CLASSES classes × NODES_PER_CLASS node records.
- Each record holds X, W, Th, M and the owning class id.
- Adds a valid/ready request handshake, registered read responses, per-class node allocation counters, a multi-cycle class-clear sweep, and error reporting.
- Sits between the GAM learning/recall controllers and storage; replaces the combinational record access.

Parameters:
- NUM_CLASSES, 4, number of classes
- NODES_PER_CLASS, 16, node slots per class
- DIM, 8, elements in X and W vectors
- DATA_W, 16, bits per vector element, Th and M
- CLS_W, $clog2(NUM_CLASSES), class index width
- NODE_W, $clog2(NODES_PER_CLASS), node index width

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  synchronous active-low reset
- req_valid  in  1  request present
- req_ready  out  1  block accepts a request this cycle
- req_op  in  2  op_T: OP_READ=0, OP_WRITE=1, OP_ALLOC=2, OP_CLEAR=3
- field_mask  in  5  {M,T,W,C,X} field enables for READ/WRITE/ALLOC
- class_i  in  CLS_W  target class
- node_i  in  NODE_W  target node (READ/WRITE)
- X_i  in  DIM*DATA_W  X data
- W_i  in  DIM*DATA_W  W data
- Th_i  in  DATA_W  threshold
- M_i  in  DATA_W  match count
- rsp_valid  out  1  one-cycle response strobe
- rsp_err  out  1  response carries an error
- class_o  out  CLS_W  stored class id / echoed class
- node_o  out  NODE_W  node index read or allocated
- X_o  out  DIM*DATA_W  X read data
- W_o  out  DIM*DATA_W  W read data
- Th_o  out  DATA_W  Th read data
- M_o  out  DATA_W  M read data
- node_count_o  out  NODE_W+1  live node count of class_i (combinational from counter)
- full_o  out  1  node_count of class_i == NODES_PER_CLASS

Behaviour:
- Reset (rst_n=0 at clk edge):
  - all counters 0, all valid bits 0, FSM to IDLE;
  - rsp_valid=0, rsp_err=0, all data outputs 0, req_ready=0 during reset, 1 in the first IDLE cycle after.
  - Record contents are not cleared.
- Handshake:
  - A request is accepted on an edge with req_valid && req_ready.
  - req_ready=1 only in IDLE.
  - One request per cycle max.
- FSM: IDLE, CLEAR.
- READ: rsp_valid exactly 1 cycle after accept.
  - Masked fields carry the record; unmasked fields hold their previous values.
  - If node_i >= node_count[class_i]: rsp_err=1, data outputs 0.
- WRITE: record updated at the accept edge, only for masked fields. The C field stores class_i.
  - Requires node_i < node_count[class_i]; otherwise no update, rsp_err=1.
  - rsp_valid pulses 1 cycle later.
- ALLOC: writes masked fields at index node_count[class_i], sets valid, and increments the counter.
  - node_o returns the allocated index on the response.
  - If full: no write, counter unchanged, rsp_err=1, node_o=0.
- CLEAR: enter CLEAR, req_ready=0.
  - Sweep idx 0..NODES_PER_CLASS-1, one per cycle: valid bit cleared, record zeroed.
  - Counter set to 0 on the final sweep cycle.
  - Return to IDLE with rsp_valid=1 the next cycle.
  - Total busy = NODES_PER_CLASS+1 cycles from accept to rsp_valid.
- Read-after-write: a READ accepted the cycle after a WRITE to the same node returns the new data. Storage is write-first.
- Reset mid-CLEAR: sweep abandoned, state as for reset.
- Counter width NODE_W+1 so full (== NODES_PER_CLASS) is representable. No wrap-around.
- class_i >= NUM_CLASSES (non-power-of-2 configs): rsp_err=1, no state change, no CLEAR entry.

Decomposition:
- GAM_package gains:
  - op_T;
  - node_rec_T (X, W vectors, Th, M, class_name);
  - field mask bit constants FM_X..FM_M;
  - DATA_W/DIM defaults.
- Natural sub-module: gam_class_counter (per-class count, alloc/clear, full flag), instantiated NUM_CLASSES times.
- Storage array and FSM stay in gam_node_memory.

Test Plan:
- Reset: rst_n=0 for 2 cycles -> rsp_valid=0, node_count_o=0 for all classes; req_ready=1 in the cycle after release.
- Allocation: ALLOC class 2 three times with X_i=8×16'h0011, Th_i=5, mask=5'h1F -> node_o 0,1,2; node_count_o=3. READ class2 node1 -> X_o=8×16'h0011, Th_o=5, class_o=2, rsp_err=0.
- Full: 16 ALLOCs to class 0 -> full_o=1. 17th ALLOC -> rsp_err=1, node_count_o stays 16.
- Masked write: WRITE class2 node0 mask=FM_M, M_i=9, Th_i=77 -> M=9, Th unchanged at 5. READ node 3 of class 2 -> rsp_err=1, data 0.
- Clear: CLEAR class 2 -> req_ready=0 for 16 cycles, rsp_valid at cycle 17, node_count_o=0. Class 0 count remains 16.
- Reset mid-operation: assert rst_n=0 at sweep idx 7 of a CLEAR on class 0 -> all counts 0, IDLE next cycle, no rsp_valid.

Source files
------------

// File: rtl/gam_node_memory_pkg.sv
// Shared types and constants for the GAM node store: request opcodes,
// field-mask bits, record layout and default geometry.
package gam_node_memory_pkg;

    localparam int NUM_CLASSES_DEF     = 4;
    localparam int NODES_PER_CLASS_DEF = 16;
    localparam int DIM_DEF             = 8;
    localparam int DATA_W_DEF          = 16;
    localparam int CLS_W_DEF           = $clog2(NUM_CLASSES_DEF);

    typedef enum logic [1:0] {
        OP_READ  = 2'd0,
        OP_WRITE = 2'd1,
        OP_ALLOC = 2'd2,
        OP_CLEAR = 2'd3
    } op_t;

    // field_mask layout is {M,T,W,C,X}
    localparam logic [4:0] FM_X = 5'b00001;
    localparam logic [4:0] FM_C = 5'b00010;
    localparam logic [4:0] FM_W = 5'b00100;
    localparam logic [4:0] FM_T = 5'b01000;
    localparam logic [4:0] FM_M = 5'b10000;

    typedef struct packed {
        logic [DIM_DEF-1:0][DATA_W_DEF-1:0] x;
        logic [DIM_DEF-1:0][DATA_W_DEF-1:0] w;
        logic [DATA_W_DEF-1:0]              th;
        logic [DATA_W_DEF-1:0]              m;
        logic [CLS_W_DEF-1:0]               class_name;
    } node_rec_t;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_CLEAR = 1'b1
    } state_t;

endpackage

// File: rtl/gam_node_memory_if.sv
// Request/response bus between the GAM controllers (master) and the node
// store (slave), including the per-class occupancy status.
interface gam_node_memory_if
    import gam_node_memory_pkg::*;
#(
    parameter int NUM_CLASSES     = NUM_CLASSES_DEF,
    parameter int NODES_PER_CLASS = NODES_PER_CLASS_DEF,
    parameter int DIM             = DIM_DEF,
    parameter int DATA_W          = DATA_W_DEF
);
    localparam int CLS_W  = $clog2(NUM_CLASSES);
    localparam int NODE_W = $clog2(NODES_PER_CLASS);

    logic                    req_valid;
    logic                    req_ready;
    op_t                     req_op;
    logic [4:0]              field_mask;
    logic [CLS_W-1:0]        class_i;
    logic [NODE_W-1:0]       node_i;
    logic [DIM*DATA_W-1:0]   X_i;
    logic [DIM*DATA_W-1:0]   W_i;
    logic [DATA_W-1:0]       Th_i;
    logic [DATA_W-1:0]       M_i;

    logic                    rsp_valid;
    logic                    rsp_err;
    logic [CLS_W-1:0]        class_o;
    logic [NODE_W-1:0]       node_o;
    logic [DIM*DATA_W-1:0]   X_o;
    logic [DIM*DATA_W-1:0]   W_o;
    logic [DATA_W-1:0]       Th_o;
    logic [DATA_W-1:0]       M_o;
    logic [NODE_W:0]         node_count_o;
    logic                    full_o;

    modport master (
        output req_valid, req_op, field_mask, class_i, node_i, X_i, W_i, Th_i, M_i,
        input  req_ready, rsp_valid, rsp_err, class_o, node_o, X_o, W_o, Th_o, M_o,
        input  node_count_o, full_o
    );

    modport slave (
        input  req_valid, req_op, field_mask, class_i, node_i, X_i, W_i, Th_i, M_i,
        output req_ready, rsp_valid, rsp_err, class_o, node_o, X_o, W_o, Th_o, M_o,
        output node_count_o, full_o
    );

endinterface

// File: rtl/gam_node_memory_class_counter.sv
// Live-node counter for one class: increments on allocation, saturates at
// NODES_PER_CLASS, and is zeroed by the final step of a class clear.
module gam_node_memory_class_counter #(
    parameter int NODES_PER_CLASS = 16,
    parameter int CNT_W           = $clog2(NODES_PER_CLASS) + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             alloc,
    input  logic             clear,
    output logic [CNT_W-1:0] count,
    output logic             full
);

    assign full = (count == CNT_W'(NODES_PER_CLASS));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (alloc && !full) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/gam_node_memory.sv
// Clocked GAM node store: per-class node records with read/write/alloc
// requests, a one-node-per-cycle class-clear sweep and error responses.
//
//   state    | meaning
//   ---------+-----------------------------------------------------------
//   ST_IDLE  | ready for a request; READ/WRITE/ALLOC respond next cycle
//   ST_CLEAR | sweeping clr_cls_q one node per cycle, requests blocked
module gam_node_memory
    import gam_node_memory_pkg::*;
#(
    parameter int NUM_CLASSES     = NUM_CLASSES_DEF,
    parameter int NODES_PER_CLASS = NODES_PER_CLASS_DEF,
    parameter int DIM             = DIM_DEF,
    parameter int DATA_W          = DATA_W_DEF
) (
    input  logic               clk,
    input  logic               rst_n,
    gam_node_memory_if.slave   bus
);

    localparam int CLS_W  = $clog2(NUM_CLASSES);
    localparam int NODE_W = $clog2(NODES_PER_CLASS);
    localparam int CNT_W  = NODE_W + 1;
    localparam int VEC_W  = DIM * DATA_W;
    localparam logic [NODE_W-1:0] LAST_IDX = NODE_W'(NODES_PER_CLASS - 1);

    logic [VEC_W-1:0]           mem_x  [NUM_CLASSES][NODES_PER_CLASS];
    logic [VEC_W-1:0]           mem_w  [NUM_CLASSES][NODES_PER_CLASS];
    logic [DATA_W-1:0]          mem_th [NUM_CLASSES][NODES_PER_CLASS];
    logic [DATA_W-1:0]          mem_m  [NUM_CLASSES][NODES_PER_CLASS];
    logic [CLS_W-1:0]           mem_c  [NUM_CLASSES][NODES_PER_CLASS];
    logic [NODES_PER_CLASS-1:0] valid_q [NUM_CLASSES];

    state_t             state_q;
    logic [NODE_W-1:0]  sweep_idx_q;
    logic [CLS_W-1:0]   clr_cls_q;

    logic [CNT_W-1:0]        count [NUM_CLASSES];
    logic [NUM_CLASSES-1:0]  full;
    logic [NUM_CLASSES-1:0]  cnt_alloc;
    logic [NUM_CLASSES-1:0]  cnt_clear;

    logic               class_ok;
    logic               accept;
    logic [CNT_W-1:0]   cur_count;
    logic               cur_full;
    logic               node_live;
    logic [NODE_W-1:0]  alloc_idx;
    logic [NODE_W-1:0]  wr_idx;
    logic               do_write;
    logic               do_alloc;
    logic               sweep_last;

    // Out-of-range class ids only exist when NUM_CLASSES is not a power of two.
    if (NUM_CLASSES == (1 << CLS_W)) begin : g_cls_pow2
        assign class_ok = 1'b1;
    end else begin : g_cls_npow2
        assign class_ok = (32'(bus.class_i) < NUM_CLASSES);
    end

    assign bus.req_ready = rst_n && (state_q == ST_IDLE);
    assign accept        = bus.req_valid && bus.req_ready;

    assign cur_count = class_ok ? count[bus.class_i] : '0;
    assign cur_full  = class_ok && full[bus.class_i];
    assign node_live = class_ok && ({1'b0, bus.node_i} < cur_count)
                       && valid_q[bus.class_i][bus.node_i];
    assign alloc_idx = cur_count[NODE_W-1:0];
    assign wr_idx    = (bus.req_op == OP_ALLOC) ? alloc_idx : bus.node_i;

    assign do_write   = accept && (bus.req_op == OP_WRITE) && node_live;
    assign do_alloc   = accept && (bus.req_op == OP_ALLOC) && class_ok && !cur_full;
    assign sweep_last = (state_q == ST_CLEAR) && (sweep_idx_q == LAST_IDX);

    assign bus.node_count_o = cur_count;
    assign bus.full_o       = cur_full;

    for (genvar g = 0; g < NUM_CLASSES; g++) begin : g_cnt
        assign cnt_alloc[g] = do_alloc && (bus.class_i == CLS_W'(g));
        assign cnt_clear[g] = sweep_last && (clr_cls_q == CLS_W'(g));

        gam_node_memory_class_counter #(
            .NODES_PER_CLASS (NODES_PER_CLASS),
            .CNT_W           (CNT_W)
        ) u_cnt (
            .clk   (clk),
            .rst_n (rst_n),
            .alloc (cnt_alloc[g]),
            .clear (cnt_clear[g]),
            .count (count[g]),
            .full  (full[g])
        );
    end

    // Record storage has no reset; writes are only suppressed while rst_n is low
    // so a reset landing mid-sweep leaves the remaining records untouched.
    always_ff @(posedge clk) begin
        if (rst_n) begin
            if (do_write || do_alloc) begin
                if (|(bus.field_mask & FM_X)) mem_x [bus.class_i][wr_idx] <= bus.X_i;
                if (|(bus.field_mask & FM_C)) mem_c [bus.class_i][wr_idx] <= bus.class_i;
                if (|(bus.field_mask & FM_W)) mem_w [bus.class_i][wr_idx] <= bus.W_i;
                if (|(bus.field_mask & FM_T)) mem_th[bus.class_i][wr_idx] <= bus.Th_i;
                if (|(bus.field_mask & FM_M)) mem_m [bus.class_i][wr_idx] <= bus.M_i;
            end
            if (state_q == ST_CLEAR) begin
                mem_x [clr_cls_q][sweep_idx_q] <= '0;
                mem_c [clr_cls_q][sweep_idx_q] <= '0;
                mem_w [clr_cls_q][sweep_idx_q] <= '0;
                mem_th[clr_cls_q][sweep_idx_q] <= '0;
                mem_m [clr_cls_q][sweep_idx_q] <= '0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q       <= ST_IDLE;
            sweep_idx_q   <= '0;
            clr_cls_q     <= '0;
            for (int c = 0; c < NUM_CLASSES; c++) valid_q[c] <= '0;
            bus.rsp_valid <= 1'b0;
            bus.rsp_err   <= 1'b0;
            bus.class_o   <= '0;
            bus.node_o    <= '0;
            bus.X_o       <= '0;
            bus.W_o       <= '0;
            bus.Th_o      <= '0;
            bus.M_o       <= '0;
        end else begin
            bus.rsp_valid <= 1'b0;
            bus.rsp_err   <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (accept) begin
                        bus.rsp_valid <= 1'b1;
                        case (bus.req_op)
                            OP_READ: begin
                                bus.node_o <= bus.node_i;
                                if (node_live) begin
                                    if (|(bus.field_mask & FM_X)) bus.X_o     <= mem_x [bus.class_i][bus.node_i];
                                    if (|(bus.field_mask & FM_C)) bus.class_o <= mem_c [bus.class_i][bus.node_i];
                                    if (|(bus.field_mask & FM_W)) bus.W_o     <= mem_w [bus.class_i][bus.node_i];
                                    if (|(bus.field_mask & FM_T)) bus.Th_o    <= mem_th[bus.class_i][bus.node_i];
                                    if (|(bus.field_mask & FM_M)) bus.M_o     <= mem_m [bus.class_i][bus.node_i];
                                end else begin
                                    bus.rsp_err <= 1'b1;
                                    bus.class_o <= bus.class_i;
                                    bus.X_o     <= '0;
                                    bus.W_o     <= '0;
                                    bus.Th_o    <= '0;
                                    bus.M_o     <= '0;
                                end
                            end
                            OP_WRITE: begin
                                bus.class_o <= bus.class_i;
                                bus.node_o  <= bus.node_i;
                                bus.rsp_err <= !node_live;
                            end
                            OP_ALLOC: begin
                                bus.class_o <= bus.class_i;
                                if (do_alloc) begin
                                    bus.node_o <= alloc_idx;
                                    valid_q[bus.class_i][alloc_idx] <= 1'b1;
                                end else begin
                                    bus.node_o  <= '0;
                                    bus.rsp_err <= 1'b1;
                                end
                            end
                            OP_CLEAR: begin
                                bus.class_o <= bus.class_i;
                                bus.node_o  <= '0;
                                if (class_ok) begin
                                    bus.rsp_valid <= 1'b0;
                                    state_q       <= ST_CLEAR;
                                    clr_cls_q     <= bus.class_i;
                                    sweep_idx_q   <= '0;
                                end else begin
                                    bus.rsp_err <= 1'b1;
                                end
                            end
                        endcase
                    end
                end
                ST_CLEAR: begin
                    valid_q[clr_cls_q][sweep_idx_q] <= 1'b0;
                    if (sweep_idx_q == LAST_IDX) begin
                        state_q       <= ST_IDLE;
                        bus.rsp_valid <= 1'b1;
                    end else begin
                        sweep_idx_q <= sweep_idx_q + 1'b1;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_gam_node_memory.sv
// Directed scoreboard bench for gam_node_memory: stimulus queues expected
// responses, a negedge monitor pops and compares them on every rsp_valid.
module tb_gam_node_memory;
    import gam_node_memory_pkg::*;

    localparam int NC     = 4;
    localparam int NPC    = 16;
    localparam int DIM    = 8;
    localparam int DW     = 16;
    localparam int CLS_W  = 2;
    localparam int NODE_W = 4;
    localparam int VW     = DIM * DW;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    gam_node_memory_if #(.NUM_CLASSES(NC), .NODES_PER_CLASS(NPC), .DIM(DIM), .DATA_W(DW)) bus ();

    gam_node_memory #(.NUM_CLASSES(NC), .NODES_PER_CLASS(NPC), .DIM(DIM), .DATA_W(DW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int checks = 0;
    int errors = 0;

    typedef struct {
        string             name;
        logic              err;
        logic              chk_node;
        logic [NODE_W-1:0] node;
        logic              chk_cls;
        logic [CLS_W-1:0]  cls;
        logic              chk_data;
        logic [VW-1:0]     x;
        logic [DW-1:0]     th;
        logic [DW-1:0]     m;
    } exp_t;

    exp_t exp_q[$];

    task automatic check(input string name, input logic [VW-1:0] act, input logic [VW-1:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    function automatic exp_t mk(input string name, input logic err,
                                input logic chk_node, input logic [NODE_W-1:0] node,
                                input logic chk_cls, input logic [CLS_W-1:0] cls,
                                input logic chk_data, input logic [VW-1:0] x,
                                input logic [DW-1:0] th, input logic [DW-1:0] m);
        exp_t e;
        e.name = name; e.err = err;
        e.chk_node = chk_node; e.node = node;
        e.chk_cls = chk_cls; e.cls = cls;
        e.chk_data = chk_data; e.x = x; e.th = th; e.m = m;
        return e;
    endfunction

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst_n && bus.rsp_valid) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_rsp actual=1 required=0");
                end else begin
                    e = exp_q.pop_front();
                    check({e.name, ".err"}, VW'(bus.rsp_err), VW'(e.err));
                    if (e.chk_node) check({e.name, ".node"}, VW'(bus.node_o), VW'(e.node));
                    if (e.chk_cls)  check({e.name, ".cls"}, VW'(bus.class_o), VW'(e.cls));
                    if (e.chk_data) begin
                        check({e.name, ".x"},  bus.X_o, e.x);
                        check({e.name, ".th"}, VW'(bus.Th_o), VW'(e.th));
                        check({e.name, ".m"},  VW'(bus.M_o), VW'(e.m));
                    end
                end
            end
        end
    end

    // Called just after a rising edge; returns just after the accepting edge.
    task automatic req(input op_t op, input logic [4:0] mask, input logic [CLS_W-1:0] cls,
                       input logic [NODE_W-1:0] node, input logic [VW-1:0] x,
                       input logic [DW-1:0] th, input logic [DW-1:0] m, input exp_t e);
        int n = 0;
        while (!bus.req_ready && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        if (n == 100) begin
            checks++;
            errors++;
            $display("FAIL ready_timeout actual=0 required=1");
        end
        bus.req_op     = op;
        bus.field_mask = mask;
        bus.class_i    = cls;
        bus.node_i     = node;
        bus.X_i        = x;
        bus.W_i        = ~x;
        bus.Th_i       = th;
        bus.M_i        = m;
        bus.req_valid  = 1'b1;
        exp_q.push_back(e);
        @(posedge clk); #1;
        bus.req_valid  = 1'b0;
    endtask

    task automatic check_count(input string name, input logic [CLS_W-1:0] cls,
                               input int cnt, input logic full);
        bus.class_i = cls;
        #1;
        check({name, ".cnt"},  VW'(bus.node_count_o), VW'(cnt));
        check({name, ".full"}, VW'(bus.full_o), VW'(full));
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1);
    end

    initial begin : stim
        logic [VW-1:0] x11;
        logic [VW-1:0] xab;
        logic [VW-1:0] xffff;
        logic [VW-1:0] zero;
        int busy;
        x11   = {8{16'h0011}};
        xab   = {8{16'hABCD}};
        xffff = {8{16'hFFFF}};
        zero  = '0;

        bus.req_valid = 1'b0; bus.req_op = OP_READ; bus.field_mask = '0;
        bus.class_i = '0; bus.node_i = '0; bus.X_i = '0; bus.W_i = '0;
        bus.Th_i = '0; bus.M_i = '0;

        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_rsp_valid", VW'(bus.rsp_valid), VW'(1'b0));
        check("rst_ready_low", VW'(bus.req_ready), VW'(1'b0));
        for (int c = 0; c < NC; c++) check_count($sformatf("rst_c%0d", c), CLS_W'(c), 0, 1'b0);
        rst_n = 1'b1;
        #1;
        check("ready_after_rst", VW'(bus.req_ready), VW'(1'b1));

        for (int i = 0; i < 3; i++)
            req(OP_ALLOC, 5'h1F, 2'd2, '0, x11, 16'd5, 16'd0,
                mk($sformatf("alloc_c2_%0d", i), 1'b0, 1'b1, NODE_W'(i), 1'b1, 2'd2, 1'b0, zero, '0, '0));
        check_count("after_alloc3_c2", 2'd2, 3, 1'b0);
        req(OP_READ, 5'h1F, 2'd2, 4'd1, zero, '0, '0,
            mk("read_c2n1", 1'b0, 1'b1, 4'd1, 1'b1, 2'd2, 1'b1, x11, 16'd5, 16'd0));

        for (int i = 0; i < NPC; i++) begin
            req(OP_ALLOC, 5'h1F, 2'd0, '0, {8{16'(i)}}, 16'(100 + i), 16'd0,
                mk($sformatf("alloc_c0_%0d", i), 1'b0, 1'b1, NODE_W'(i), 1'b1, 2'd0, 1'b0, zero, '0, '0));
            if (i == NPC - 2) check_count("c0_one_left", 2'd0, NPC - 1, 1'b0);
        end
        check_count("c0_full", 2'd0, NPC, 1'b1);
        req(OP_ALLOC, 5'h1F, 2'd0, '0, xffff, 16'd1, 16'd1,
            mk("alloc_c0_over", 1'b1, 1'b1, 4'd0, 1'b1, 2'd0, 1'b0, zero, '0, '0));
        check_count("c0_still_full", 2'd0, NPC, 1'b1);

        req(OP_WRITE, FM_M, 2'd2, 4'd0, xffff, 16'd77, 16'd9,
            mk("write_c2n0_m", 1'b0, 1'b1, 4'd0, 1'b1, 2'd2, 1'b0, zero, '0, '0));
        req(OP_READ, 5'h1F, 2'd2, 4'd0, zero, '0, '0,
            mk("read_c2n0", 1'b0, 1'b1, 4'd0, 1'b1, 2'd2, 1'b1, x11, 16'd5, 16'd9));
        req(OP_READ, FM_T, 2'd0, 4'd5, zero, '0, '0,
            mk("read_c0n5_th_only", 1'b0, 1'b1, 4'd5, 1'b1, 2'd2, 1'b1, x11, 16'd105, 16'd9));
        req(OP_READ, 5'h1F, 2'd2, 4'd3, zero, '0, '0,
            mk("read_c2n3_dead", 1'b1, 1'b0, '0, 1'b0, '0, 1'b1, zero, 16'd0, 16'd0));
        req(OP_WRITE, 5'h1F, 2'd2, 4'd3, xffff, 16'd1, 16'd1,
            mk("write_c2n3_dead", 1'b1, 1'b0, '0, 1'b0, '0, 1'b0, zero, '0, '0));

        req(OP_WRITE, FM_X, 2'd0, 4'd3, xab, 16'd7, 16'd7,
            mk("write_c0n3_x", 1'b0, 1'b1, 4'd3, 1'b1, 2'd0, 1'b0, zero, '0, '0));
        req(OP_READ, FM_X, 2'd0, 4'd3, zero, '0, '0,
            mk("raw_c0n3", 1'b0, 1'b1, 4'd3, 1'b0, '0, 1'b1, xab, 16'd0, 16'd0));

        req(OP_CLEAR, 5'h00, 2'd2, '0, zero, '0, '0,
            mk("clear_c2", 1'b0, 1'b0, '0, 1'b1, 2'd2, 1'b0, zero, '0, '0));
        busy = 0;
        while (!bus.req_ready && busy < 40) begin
            busy++;
            @(posedge clk); #1;
        end
        check("clear_busy_cycles", VW'(busy), VW'(NPC));
        check("clear_rsp_cycle", VW'(bus.rsp_valid), VW'(1'b1));
        check_count("c2_after_clear", 2'd2, 0, 1'b0);
        check_count("c0_after_clear", 2'd0, NPC, 1'b1);
        req(OP_READ, 5'h1F, 2'd2, 4'd0, zero, '0, '0,
            mk("read_c2n0_cleared", 1'b1, 1'b0, '0, 1'b0, '0, 1'b1, zero, 16'd0, 16'd0));

        req(OP_CLEAR, 5'h00, 2'd0, '0, zero, '0, '0,
            mk("clear_c0_aborted", 1'b0, 1'b0, '0, 1'b0, '0, 1'b0, zero, '0, '0));
        repeat (7) @(posedge clk);
        #1;
        check("clear_c0_busy_idx7", VW'(bus.req_ready), VW'(1'b0));
        rst_n = 1'b0;
        exp_q.delete();
        @(posedge clk); #1;
        check("midclr_rst_rsp_valid", VW'(bus.rsp_valid), VW'(1'b0));
        for (int c = 0; c < NC; c++) check_count($sformatf("midclr_c%0d", c), CLS_W'(c), 0, 1'b0);
        rst_n = 1'b1;
        #1;
        check("midclr_ready_after", VW'(bus.req_ready), VW'(1'b1));
        repeat (20) @(posedge clk);
        #1;
        req(OP_READ, 5'h1F, 2'd0, 4'd10, zero, '0, '0,
            mk("read_c0_after_rst", 1'b1, 1'b0, '0, 1'b0, '0, 1'b1, zero, 16'd0, 16'd0));
        req(OP_ALLOC, FM_T, 2'd0, '0, zero, 16'd3, '0,
            mk("alloc_c0_after_rst", 1'b0, 1'b1, 4'd0, 1'b1, 2'd0, 1'b0, zero, '0, '0));
        check_count("c0_after_rst_alloc", 2'd0, 1, 1'b0);

        repeat (4) @(posedge clk);
        #1;
        check("queue_drained", VW'(exp_q.size()), VW'(0));
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
